aud_recorder: RTL and testbench

AUD_RECORDER -- requirements
Module: aud_recorder

---
 rtl/aud_pkg.sv | 20 ++
 rtl/aud_deser.sv | 47 ++++
 rtl/aud_recorder.sv | 151 +++++++++++++++
 tb/tb_aud_recorder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared audio definitions used by the recorder and the player.
//   SAMPLE_W     : width of one PCM sample word (16)
//   CNT_W        : width of the serial bit counter
//   CNT_TOP      : counter value for the MSB (first bit after the delay slot)
//   aud_state_t  : capture/playback state encoding
package aud_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SAMPLE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_SHIFT = 3'd2,
    S_GAP   = 3'd3,
    S_PAUSE = 3'd4
  } aud_state_t;

endpackage

// File: rtl/aud_deser.sv
// Serial-to-parallel shifter for one I2S channel word, MSB first.
// Ports:
//   i_bclk, i_rst_n : bit clock, asynchronous active-low reset
//   i_load          : preset the bit counter to the MSB position
//   i_en            : sample i_bit into word[counter] and count down
//   i_bit           : serial data bit
//   o_word          : assembled sample word
//   o_done          : one-cycle pulse the cycle after bit 0 was sampled
//   o_last          : counter is at bit 0 (current enabled cycle ends the word)
module aud_deser
  import aud_pkg::*;
(
  input  logic                       i_bclk,
  input  logic                       i_rst_n,
  input  logic                       i_load,
  input  logic                       i_en,
  input  logic                       i_bit,
  output logic signed [SAMPLE_W-1:0] o_word,
  output logic                       o_done,
  output logic                       o_last
);

  logic [CNT_W-1:0]           cnt;
  logic signed [SAMPLE_W-1:0] shreg;

  assign o_word = shreg;
  assign o_last = (cnt == '0);

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= CNT_TOP;
      shreg  <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_load) begin
        cnt <= CNT_TOP;
      end else if (i_en) begin
        shreg[cnt] <= i_bit;
        // Counter wraps from 0 back to the MSB position on its own.
        cnt        <= cnt - 1'b1;
        if (cnt == '0) o_done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// I2S left-channel recorder: captures 16-bit samples from the ADC and hands
// them to memory through a one-word valid/ready buffer.
// Parameters:
//   ADDR_W   : sample address width
//   MAX_ADDR : last writable address; its handshake ends the recording
// Ports:
//   i_bclk, i_rst_n             : codec bit clock, asynchronous active-low reset
//   i_start, i_pause, i_stop    : single-cycle control pulses
//   i_adclrck, i_adcdat         : I2S frame clock (low = left) and serial data
//   o_wr_valid, i_wr_ready      : memory write handshake
//   o_data, o_address           : sample word and its address
//   o_len                       : number of words written
//   o_busy, o_full, o_overrun   : status flags
module aud_recorder
  import aud_pkg::*;
#(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = '1
) (
  input  logic                       i_bclk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_pause,
  input  logic                       i_stop,
  input  logic                       i_adclrck,
  input  logic                       i_adcdat,
  output logic                       o_wr_valid,
  input  logic                       i_wr_ready,
  output logic signed [SAMPLE_W-1:0] o_data,
  output logic [ADDR_W-1:0]          o_address,
  output logic [ADDR_W:0]            o_len,
  output logic                       o_busy,
  output logic                       o_full,
  output logic                       o_overrun
);

  aud_state_t                 state, state_n;
  logic                       pause_pend, pause_pend_n;
  logic                       lrck_q;
  logic                       lrck_fall;
  logic                       hs, hs_last;
  logic                       deser_load, deser_en;
  logic                       deser_done, deser_last;
  logic signed [SAMPLE_W-1:0] deser_word;
  logic [ADDR_W-1:0]          addr;

  assign lrck_fall = lrck_q && !i_adclrck;
  assign hs        = o_wr_valid && i_wr_ready;
  assign hs_last   = hs && (o_address == MAX_ADDR);
  assign o_busy    = (state != S_IDLE);
  // A stop or the final handshake discards whatever is being shifted in.
  assign deser_en  = (state == S_SHIFT) && !i_stop && !hs_last;

  aud_deser u_deser (
    .i_bclk  (i_bclk),
    .i_rst_n (i_rst_n),
    .i_load  (deser_load),
    .i_en    (deser_en),
    .i_bit   (i_adcdat),
    .o_word  (deser_word),
    .o_done  (deser_done),
    .o_last  (deser_last)
  );

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      pause_pend <= 1'b0;
      lrck_q     <= 1'b1;
    end else begin
      state      <= state_n;
      pause_pend <= pause_pend_n;
      lrck_q     <= i_adclrck;
    end
  end

  always_comb begin
    state_n      = state;
    pause_pend_n = pause_pend;
    deser_load   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_start) state_n = S_ARM;
      end
      S_ARM, S_GAP: begin
        if (i_stop) begin
          state_n = S_IDLE;
        end else if (i_pause) begin
          state_n = S_PAUSE;
        end else if (lrck_fall) begin
          // This cycle is the I2S one-bit delay slot; MSB arrives next.
          state_n    = S_SHIFT;
          deser_load = 1'b1;
        end
      end
      S_SHIFT: begin
        if (i_stop) begin
          state_n = S_IDLE;
        end else begin
          // A pause here is held until the word in flight completes.
          if (i_pause) pause_pend_n = 1'b1;
          if (deser_last) state_n = (pause_pend || i_pause) ? S_PAUSE : S_GAP;
        end
      end
      S_PAUSE: begin
        if (i_stop)                  state_n = S_IDLE;
        else if (i_pause || i_start) state_n = S_ARM;
      end
      default: state_n = S_IDLE;
    endcase
    if (hs_last) state_n = S_IDLE;
    if (state_n != S_SHIFT) pause_pend_n = 1'b0;
  end

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_valid <= 1'b0;
      o_data     <= '0;
      o_address  <= '0;
      addr       <= '0;
      o_len      <= '0;
      o_full     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      if (hs) begin
        o_wr_valid <= 1'b0;
        addr       <= addr + 1'b1;
        o_len      <= o_len + 1'b1;
        if (hs_last) o_full <= 1'b1;
      end
      // The buffer is judged by its state this cycle, so a word completing on
      // the handshake cycle itself is still an overrun.
      if (deser_done) begin
        if (o_wr_valid) begin
          o_overrun <= 1'b1;
        end else begin
          o_wr_valid <= 1'b1;
          o_data     <= deser_word;
          o_address  <= addr;
        end
      end
      if (state == S_IDLE && i_start) begin
        addr      <= '0;
        o_len     <= '0;
        o_full    <= 1'b0;
        o_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder: I2S frames are driven on the falling
// clock edge, expected writes are queued when a frame is sent and popped when
// the memory handshake is observed.
module tb_aud_recorder;

  localparam int ADDR_W = 20;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
  } exp_t;

  logic               i_bclk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic               i_pause = 1'b0;
  logic               i_stop = 1'b0;
  logic               i_adclrck = 1'b1;
  logic               i_adcdat = 1'b0;
  logic               i_wr_ready = 1'b1;
  logic               o_wr_valid;
  logic signed [15:0] o_data;
  logic [ADDR_W-1:0]  o_address;
  logic [ADDR_W:0]    o_len;
  logic               o_busy, o_full, o_overrun;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   rise_cyc = 0;
  int   n_wr = 0;
  exp_t sb[$];

  logic              prev_valid = 1'b0;
  logic              prev_hs = 1'b0;
  logic [15:0]       prev_data = '0;
  logic [ADDR_W-1:0] prev_addr = '0;

  aud_recorder #(.ADDR_W(ADDR_W), .MAX_ADDR(20'd3)) dut (
    .i_bclk     (i_bclk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_pause    (i_pause),
    .i_stop     (i_stop),
    .i_adclrck  (i_adclrck),
    .i_adcdat   (i_adcdat),
    .o_wr_valid (o_wr_valid),
    .i_wr_ready (i_wr_ready),
    .o_data     (o_data),
    .o_address  (o_address),
    .o_len      (o_len),
    .o_busy     (o_busy),
    .o_full     (o_full),
    .o_overrun  (o_overrun)
  );

  always #5 i_bclk = ~i_bclk;
  always @(posedge i_bclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handshake monitor, sampled mid-cycle.
  always @(negedge i_bclk) begin
    exp_t e;
    logic hs;
    #2;
    hs = 1'b0;
    if (i_rst_n) begin
      if (o_wr_valid && !prev_valid) rise_cyc = cyc;
      if (prev_valid && !prev_hs && o_wr_valid) begin
        check("hold_data", 32'($unsigned(o_data)), 32'(prev_data));
        check("hold_addr", 32'(o_address), 32'(prev_addr));
      end
      hs = o_wr_valid && i_wr_ready;
      if (hs) begin
        n_wr++;
        if (sb.size() == 0) begin
          check("unexpected_wr", 32'(o_address), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("wr_data", 32'($unsigned(o_data)), 32'(e.d));
          check("wr_addr", 32'(o_address), 32'(e.a));
        end
      end
    end
    prev_valid = o_wr_valid && i_rst_n;
    prev_hs    = hs;
    prev_data  = $unsigned(o_data);
    prev_addr  = o_address;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // kind: 0 = pause pulse, 1 = stop pulse, 2 = assert reset (held low)
  task automatic send_frame(input logic [15:0] w, input int ctl_at, input int kind);
    for (int c = 0; c < 64; c++) begin
      @(negedge i_bclk);
      i_pause   = 1'b0;
      i_stop    = 1'b0;
      i_adclrck = (c < 32) ? 1'b0 : 1'b1;
      if (c == 0) fall_cyc = cyc;
      if (c >= 1 && c <= 16) i_adcdat = w[16-c];
      else                   i_adcdat = 1'($urandom_range(0, 1));
      if (c == ctl_at) begin
        case (kind)
          0:       i_pause = 1'b1;
          1:       i_stop  = 1'b1;
          default: i_rst_n = 1'b0;
        endcase
      end
    end
    @(negedge i_bclk);
    i_pause = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic pulse(input int kind);
    @(negedge i_bclk);
    case (kind)
      0:       i_start = 1'b1;
      1:       i_pause = 1'b1;
      default: i_stop  = 1'b1;
    endcase
    @(negedge i_bclk);
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic push(input int addr, input logic [15:0] w);
    sb.push_back({ADDR_W'(addr), w});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && (sb.size() != 0 || o_wr_valid); i++) @(negedge i_bclk);
    @(negedge i_bclk);
    #3;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},    32'($unsigned(o_data)), 32'd0);
    check({tag, "_addr"},    32'(o_address), 32'd0);
    check({tag, "_len"},     32'(o_len), 32'd0);
    check({tag, "_valid"},   32'(o_wr_valid), 32'd0);
    check({tag, "_busy"},    32'(o_busy), 32'd0);
    check({tag, "_full"},    32'(o_full), 32'd0);
    check({tag, "_overrun"}, 32'(o_overrun), 32'd0);
  endtask

  logic [15:0] t2_words[3] = '{16'h1234, 16'hFFFF, 16'h0000};
  logic [15:0] t4_words[5] = '{16'h0F0F, 16'hF00D, 16'h7FFF, 16'h8000, 16'hBEEF};

  initial begin
    // Reset state
    repeat (3) @(negedge i_bclk);
    #3;
    check_all_zero("rst");
    @(negedge i_bclk);
    i_rst_n = 1'b1;

    // Single frame, write latency
    pulse(0);
    check("t1_busy", 32'(o_busy), 32'd1);
    check("t1_len0", 32'(o_len), 32'd0);
    push(0, 16'h8001);
    send_frame(16'h8001, -1, 0);
    check("t1_latency", 32'(rise_cyc - fall_cyc), 32'd18);
    drain("t1_drain");
    check("t1_len", 32'(o_len), 32'd1);

    // Three back-to-back frames
    pulse(2);
    pulse(0);
    for (int k = 0; k < 3; k++) begin
      push(k, t2_words[k]);
      send_frame(t2_words[k], -1, 0);
    end
    drain("t2_drain");
    check("t2_len", 32'(o_len), 32'd3);
    check("t2_overrun", 32'(o_overrun), 32'd0);

    // Memory stalled across two frames
    pulse(2);
    pulse(0);
    i_wr_ready = 1'b0;
    push(0, 16'h1111);
    send_frame(16'h1111, -1, 0);
    send_frame(16'h2222, -1, 0);
    #3;
    check("t3_overrun", 32'(o_overrun), 32'd1);
    check("t3_valid", 32'(o_wr_valid), 32'd1);
    check("t3_data", 32'($unsigned(o_data)), 32'h1111);
    check("t3_addr", 32'(o_address), 32'd0);
    @(negedge i_bclk);
    i_wr_ready = 1'b1;
    drain("t3_drain");
    check("t3_len", 32'(o_len), 32'd1);

    // Fill to MAX_ADDR = 3
    pulse(2);
    pulse(0);
    check("t4_overrun_clr", 32'(o_overrun), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) push(k, t4_words[k]);
      send_frame(t4_words[k], -1, 0);
    end
    drain("t4_drain");
    check("t4_full", 32'(o_full), 32'd1);
    check("t4_busy", 32'(o_busy), 32'd0);
    check("t4_len", 32'(o_len), 32'd4);

    // Pause mid-word, skip two frames, resume
    pulse(0);
    check("t5_full_clr", 32'(o_full), 32'd0);
    push(0, 16'hA5A5);
    send_frame(16'hA5A5, 8, 0);
    send_frame(16'h1357, -1, 0);
    send_frame(16'h2468, -1, 0);
    check("t5_busy_paused", 32'(o_busy), 32'd1);
    pulse(1);
    push(1, 16'h5A5A);
    send_frame(16'h5A5A, -1, 0);
    drain("t5_drain");
    check("t5_len", 32'(o_len), 32'd2);

    // Stop at bit 8, then reset mid-frame
    pulse(2);
    pulse(0);
    begin
      int wr0;
      wr0 = n_wr;
      send_frame(16'hC3C3, 8, 1);
      #3;
      check("t6_busy", 32'(o_busy), 32'd0);
      check("t6_valid", 32'(o_wr_valid), 32'd0);
      check("t6_len", 32'(o_len), 32'd0);
      pulse(0);
      send_frame(16'h3C3C, 5, 2);
      #3;
      check_all_zero("t6_rst");
      @(negedge i_bclk);
      i_rst_n = 1'b1;
      repeat (40) @(negedge i_bclk);
      #3;
      check("t6_no_write", 32'(n_wr - wr0), 32'd0);
      check("t6_valid_after", 32'(o_wr_valid), 32'd0);
      check("t6_sb_empty", 32'(sb.size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
